imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Accepts one RISC-V instruction per cycle over a valid/ready handshake and decodes its immediate, sign-extended to XLEN.
- Also emits an immediate-format code, an illegal-opcode flag and a pass-through tag.
- Sits between the fetch/decode boundary and the execute-stage operand mux; a 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- XLEN, 32, output immediate width; 32 or 64 only, any other value is an elaboration error.
- TAG_WIDTH, 32, width of the sideband tag (typically PC) carried with each instruction.
- SUPPORT_CSR, 1, 1 decodes CSR-immediate forms as Z-type; 0 treats all SYSTEM opcodes as NONE.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- Flush  input  1  synchronous pipeline clear.
- InValid  input  1  Instruction/InTag valid.
- InReady  output  1  block can accept this cycle.
- Instruction  input  32  raw instruction word.
- InTag  input  TAG_WIDTH  sideband carried with the instruction.
- OutValid  output  1  output word valid.
- OutReady  input  1  consumer accepts.
- ImmData  output  XLEN  decoded immediate.
- ImmType  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- Illegal  output  1  unrecognised opcode.
- OutTag  output  TAG_WIDTH  tag of the output word.

Behaviour:
- Reset (rst=1 at a clk edge): OutValid=0, ImmData=0, ImmType=0, Illegal=0, OutTag=0, skid buffer empty, InReady=1 from the next cycle. Reset mid-stream drops all held entries.
- Handshakes:
  - Input transfer on InValid&&InReady.
  - Output transfer on OutValid&&OutReady.
  - Output fields are stable while OutValid&&!OutReady.
- Latency: an accepted instruction appears on the outputs on the next cycle when the output register is free.
- Storage: output register plus one skid entry, occupancy 0..2.
  - InReady = (occupancy<2), registered, with no combinational path from OutReady.
  - Full (occupancy 2): InReady=0; input is not sampled.
  - Output register occupied and not draining, with an input accepted: the input goes to skid.
  - On drain: skid moves to the output register. If skid is empty and an input arrives in the same cycle, the input loads the output register directly.
  - Order is strictly FIFO.
- Flush (synchronous): occupancy becomes 0 and OutValid=0 next cycle. Input in the same cycle is discarded. Flush has priority over all other events except rst.
- Decode (opcode = Instruction[6:0]); all immediates are sign-extended from their top bit to XLEN:
  - I-type (ImmType 1): opcodes 0010011, 0000011, 1100111, and 0011011 when XLEN=64. Imm = inst[31:20].
  - S-type (ImmType 2): 0100011. Imm = {inst[31:25], inst[11:7]}.
  - B-type (ImmType 3): 1100011. Imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (ImmType 4): 0110111, 0010111. Imm = {inst[31:12], 12'b0}, then sign-extended for XLEN=64.
  - J-type (ImmType 5): 1101111. Imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Z-type (ImmType 6): 1110011 with inst[14]=1 and SUPPORT_CSR=1. Imm = zero-extended inst[19:15].
  - NONE (ImmType 0), legal, imm 0: 0110011, 0001111, 1110011 otherwise, and 0111011 when XLEN=64.
  - Illegal=1 with ImmType 0 and imm 0: any other opcode, including inst[1:0]!=11, and 0011011/0111011 when XLEN=32.

Test Plan:
- Reset, then ADDI 0xFFF00093, OutReady=1 -> next cycle OutValid=1, ImmData=0xFFFFFFFF, ImmType=1, Illegal=0, OutTag=InTag.
- LUI 0xABCDE0B7 at XLEN=32 -> 0xABCDE000; at XLEN=64 -> 0xFFFFFFFFABCDE000; ImmType=4 in both.
- Back-to-back, one per cycle, OutReady=1: JAL 0xFFDFF06F, BEQ 0x00000463, SW 0x0020A623, CSRRWI 0x3002D073 -> ImmData 0xFFFFFFFC, 0x8, 0xC, 0x5 on consecutive cycles; types 5, 3, 2, 6; with SUPPORT_CSR=0 the CSRRWI gives type 0, imm 0.
- Backpressure: OutReady=0 while offering tags 1, 2, 3 on consecutive cycles -> tag 1 in output register, tag 2 in skid, InReady=0 and tag 3 held off; raising OutReady drains 1, 2, 3 in order with nothing lost or duplicated.
- Input 0xFFFFFFFF -> Illegal=1, ImmType=0, ImmData=0. Input 0x00000033 (ADD) -> Illegal=0, ImmType=0, ImmData=0. Opcode 0011011 at XLEN=32 -> Illegal=1.
- Flush with occupancy 2 and a concurrent InValid -> next cycle OutValid=0, InReady=1, and none of the three instructions ever appear. Same sequence with rst instead of Flush -> all outputs zero.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes one instruction per cycle into a
// sign-extended immediate, format code, illegal flag and tag, behind a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int TAG_WIDTH   = 32,
    parameter bit SUPPORT_CSR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [31:0]          Instruction,
    input  logic [TAG_WIDTH-1:0] InTag,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [XLEN-1:0]      ImmData,
    output logic [2:0]           ImmType,
    output logic                 Illegal,
    output logic [TAG_WIDTH-1:0] OutTag
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
    localparam logic [2:0] TYPE_Z    = 3'd6;

    logic [6:0]      w_opcode;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_illegal;

    // Every format is built as a 32-bit signed value first, then widened once to XLEN.
    always_comb begin
        w_opcode  = Instruction[6:0];
        w_imm32   = '0;
        w_type    = TYPE_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_type  = TYPE_I;
                w_imm32 = {{20{Instruction[31]}}, Instruction[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    w_type  = TYPE_I;
                    w_imm32 = {{20{Instruction[31]}}, Instruction[31:20]};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                w_type  = TYPE_S;
                w_imm32 = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            end
            7'b1100011: begin
                w_type  = TYPE_B;
                w_imm32 = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                           Instruction[30:25], Instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type  = TYPE_U;
                w_imm32 = {Instruction[31:12], 12'b0};
            end
            7'b1101111: begin
                w_type  = TYPE_J;
                w_imm32 = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                           Instruction[20], Instruction[30:21], 1'b0};
            end
            7'b1110011: begin
                if (SUPPORT_CSR && Instruction[14]) begin
                    w_type  = TYPE_Z;
                    w_imm32 = {27'b0, Instruction[19:15]};
                end
            end
            7'b0110011, 7'b0001111: begin
                w_type = TYPE_NONE;
            end
            7'b0111011: begin
                w_illegal = (XLEN != 64);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        w_imm = XLEN'($signed(w_imm32));
    end

    // Handshake: a word moves on a side only when that side's valid and ready are both
    // high at the clock edge; OutValid and the output fields hold while OutReady is low.
    logic                 r_out_valid;
    logic [XLEN-1:0]      r_out_imm;
    logic [2:0]           r_out_type;
    logic                 r_out_illegal;
    logic [TAG_WIDTH-1:0] r_out_tag;

    logic                 r_skid_valid;
    logic [XLEN-1:0]      r_skid_imm;
    logic [2:0]           r_skid_type;
    logic                 r_skid_illegal;
    logic [TAG_WIDTH-1:0] r_skid_tag;

    logic w_accept;
    logic w_out_free;

    // Occupancy 2 is exactly "skid holds a word", so InReady comes straight from a flop.
    assign InReady    = !r_skid_valid;
    assign w_accept   = InValid && InReady;
    assign w_out_free = !r_out_valid || OutReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_type     <= TYPE_NONE;
            r_out_illegal  <= 1'b0;
            r_out_tag      <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_type    <= TYPE_NONE;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= '0;
        end else if (Flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid   <= 1'b1;
                r_out_imm     <= r_skid_imm;
                r_out_type    <= r_skid_type;
                r_out_illegal <= r_skid_illegal;
                r_out_tag     <= r_skid_tag;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_imm     <= w_imm;
                r_out_type    <= w_type;
                r_out_illegal <= w_illegal;
                r_out_tag     <= InTag;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_imm;
            r_skid_type    <= w_type;
            r_skid_illegal <= w_illegal;
            r_skid_tag     <= InTag;
        end
    end

    assign OutValid = r_out_valid;
    assign ImmData  = r_out_imm;
    assign ImmType  = r_out_type;
    assign Illegal  = r_out_illegal;
    assign OutTag   = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives an XLEN=32/CSR and an XLEN=64/no-CSR instance with
// identical stimulus and compares both against fixed vectors and a queue-based model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, in_tag;

    logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] imm32;
        logic [2:0]  typ32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  typ64;
        logic        ill64;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [2:0]  typ32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  typ64;
        logic        ill64;
    } vec_t;

    typedef struct packed {
        logic [63:0] v;
        logic [2:0]  typ;
        logic        ill;
    } dec_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    exp_t exp_q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(32), .SUPPORT_CSR(1'b1)) dut32 (
        .clk(clk), .rst(rst), .Flush(flush), .InValid(in_valid), .InReady(rdy32),
        .Instruction(instr), .InTag(in_tag), .OutValid(ov32), .OutReady(out_ready),
        .ImmData(imm32), .ImmType(typ32), .Illegal(ill32), .OutTag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(32), .SUPPORT_CSR(1'b0)) dut64 (
        .clk(clk), .rst(rst), .Flush(flush), .InValid(in_valid), .InReady(rdy64),
        .Instruction(instr), .InTag(in_tag), .OutValid(ov64), .OutReady(out_ready),
        .ImmData(imm64), .ImmType(typ64), .Illegal(ill64), .OutTag(tag64)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // reference model: field extraction plus integer sign adjustment
    function automatic longint sext(input longint raw, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (raw >= half) ? raw - (half << 1) : raw;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] inst, input bit is64, input bit csr);
        dec_t d;
        longint v;
        v     = 0;
        d.typ = 3'd0;
        d.ill = 1'b0;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67: begin d.typ = 3'd1; v = sext(longint'(inst[31:20]), 12); end
            7'h1B: begin
                if (is64) begin d.typ = 3'd1; v = sext(longint'(inst[31:20]), 12); end
                else d.ill = 1'b1;
            end
            7'h23: begin d.typ = 3'd2; v = sext(longint'({inst[31:25], inst[11:7]}), 12); end
            7'h63: begin
                d.typ = 3'd3;
                v = sext(longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
            end
            7'h37, 7'h17: begin d.typ = 3'd4; v = sext(longint'(inst[31:12]), 20) * 4096; end
            7'h6F: begin
                d.typ = 3'd5;
                v = sext(longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
            end
            7'h73: if (csr && inst[14]) begin d.typ = 3'd6; v = longint'(inst[19:15]); end
            7'h33, 7'h0F: ;
            7'h3B: d.ill = !is64;
            default: d.ill = 1'b1;
        endcase
        d.v = v;
        return d;
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] tag);
        exp_t e;
        dec_t d32, d64;
        d32     = ref_decode(inst, 1'b0, 1'b1);
        d64     = ref_decode(inst, 1'b1, 1'b0);
        e.tag   = tag;
        e.imm32 = d32.v[31:0];
        e.typ32 = d32.typ;
        e.ill32 = d32.ill;
        e.imm64 = d64.v;
        e.typ64 = d64.typ;
        e.ill64 = d64.ill;
        return e;
    endfunction

    function automatic exp_t vec2exp(input vec_t v, input logic [31:0] tag);
        exp_t e;
        e.tag   = tag;
        e.imm32 = v.imm32;
        e.typ32 = v.typ32;
        e.ill32 = v.ill32;
        e.imm64 = v.imm64;
        e.typ64 = v.typ64;
        e.ill64 = v.ill64;
        return e;
    endfunction

    // scoreboard helpers
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input exp_t e);
        chk({name, " valid32"}, 64'(ov32), 64'd1);
        chk({name, " valid64"}, 64'(ov64), 64'd1);
        chk({name, " imm32"}, 64'(imm32), 64'(e.imm32));
        chk({name, " type32"}, 64'(typ32), 64'(e.typ32));
        chk({name, " ill32"}, 64'(ill32), 64'(e.ill32));
        chk({name, " tag32"}, 64'(tag32), 64'(e.tag));
        chk({name, " imm64"}, imm64, e.imm64);
        chk({name, " type64"}, 64'(typ64), 64'(e.typ64));
        chk({name, " ill64"}, 64'(ill64), 64'(e.ill64));
        chk({name, " tag64"}, 64'(tag64), 64'(e.tag));
    endtask

    task automatic chk_zero(input string name);
        chk({name, " valid32"}, 64'(ov32), 64'd0);
        chk({name, " valid64"}, 64'(ov64), 64'd0);
        chk({name, " imm32"}, 64'(imm32), 64'd0);
        chk({name, " imm64"}, imm64, 64'd0);
        chk({name, " types"}, 64'({typ32, typ64}), 64'd0);
        chk({name, " illegal"}, 64'({ill32, ill64}), 64'd0);
        chk({name, " tags"}, {tag32, tag64}, 64'd0);
        chk({name, " ready"}, 64'({rdy32, rdy64}), 64'h3);
    endtask

    // driver tasks
    task automatic drive(input logic [31:0] inst, input logic [31:0] tag);
        in_valid = 1'b1;
        instr    = inst;
        in_tag   = tag;
    endtask

    task automatic fill_two(input logic [31:0] tag0);
        out_ready = 1'b0;
        drive(32'h00100093, tag0);
        @(negedge clk);
        drive(32'h00200093, tag0 + 1);
        @(negedge clk);
        chk("fill ready", 64'({rdy32, rdy64}), 64'h0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[13] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h3B};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
        return r;
    endfunction

    initial begin
        logic [31:0] got[$];
        bit          acc_now, in_fire, out_fire;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hABCDE0B7, 32'hABCDE000, 3'd4, 1'b0, 64'hFFFFFFFFABCDE000, 3'd4, 1'b0};
        vecs[2]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
        vecs[3]  = '{32'h00000463, 32'h00000008, 3'd3, 1'b0, 64'h8, 3'd3, 1'b0};
        vecs[4]  = '{32'h0020A623, 32'h0000000C, 3'd2, 1'b0, 64'hC, 3'd2, 1'b0};
        vecs[5]  = '{32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h0, 3'd0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        vecs[7]  = '{32'h00000033, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        vecs[8]  = '{32'hFFF0009B, 32'h0, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vecs[9]  = '{32'h0000003B, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0};
        vecs[10] = '{32'h7FF02083, 32'h000007FF, 3'd1, 1'b0, 64'h7FF, 3'd1, 1'b0};
        vecs[11] = '{32'h00000073, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        vecs[12] = '{32'h80000017, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vecs[13] = '{32'h00C08067, 32'h0000000C, 3'd1, 1'b0, 64'hC, 3'd1, 1'b0};
        vecs[14] = '{32'h00000010, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1};
        vecs[15] = '{32'h0000000F, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0};
        vecs[16] = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
        vecs[17] = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};

        // reset
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // table vectors, one per cycle, consumer always ready
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) chk_out($sformatf("vec%0d", i - 1), vec2exp(vecs[i - 1], 32'h100 + i - 1));
            if (i < NV) drive(vecs[i].inst, 32'h100 + i);
            else in_valid = 1'b0;
            @(negedge clk);
        end
        chk("drain idle", 64'({ov32, ov64}), 64'h0);

        // backpressure: tag 1 in output, tag 2 in skid, tag 3 held off
        out_ready = 1'b0;
        drive(32'h00100093, 32'd1);
        @(negedge clk);
        chk("bp tag after 1", 64'(tag32), 64'd1);
        chk("bp ready after 1", 64'({rdy32, rdy64}), 64'h3);
        drive(32'h00200093, 32'd2);
        @(negedge clk);
        chk("bp ready after 2", 64'({rdy32, rdy64}), 64'h0);
        drive(32'h00300093, 32'd3);
        @(negedge clk);
        chk("bp held tag", 64'({tag32, tag64}), {32'd1, 32'd1});
        chk("bp held imm", 64'(imm32), 64'd1);
        chk("bp held ready", 64'(rdy32), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (ov32 && out_ready) got.push_back(tag32);
            acc_now = in_valid && rdy32;
            @(negedge clk);
            if (acc_now) in_valid = 1'b0;
        end
        chk("bp drained count", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size() && k < 3; k++)
            chk($sformatf("bp order %0d", k), 64'(got[k]), 64'(k + 1));

        // flush at occupancy 2 with a concurrent input
        fill_two(32'd10);
        flush = 1'b1;
        drive(32'h00500093, 32'd12);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush valid", 64'({ov32, ov64}), 64'h0);
        chk("flush ready", 64'({rdy32, rdy64}), 64'h3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("flush quiet %0d", c), 64'({ov32, ov64}), 64'h0);
        end

        // reset mid-stream with the same shape
        fill_two(32'd20);
        rst = 1'b1;
        drive(32'h00500093, 32'd22);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk_zero("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midreset quiet %0d", c), 64'({ov32, ov64}), 64'h0);
        end

        // randomized traffic against the queue model
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd ready32", 64'(rdy32), 64'(exp_q.size() < 2));
            chk("rnd ready64", 64'(rdy64), 64'(exp_q.size() < 2));
            if (exp_q.size() > 0) chk_out("rnd", exp_q[0]);
            else chk("rnd idle", 64'({ov32, ov64}), 64'h0);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 3);
            instr     = rand_inst();
            in_tag    = $urandom();
            in_fire   = in_valid && (exp_q.size() < 2);
            out_fire  = out_ready && (exp_q.size() > 0);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_fire) void'(exp_q.pop_front());
                if (in_fire) exp_q.push_back(model(instr, in_tag));
            end
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0;

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
